// File: rtl/dtc_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : dtc_pulse_gen
// Description : Digital-to-time converter. Accepts an N-bit binary code and
//               emits one pulse of exactly `code` clock cycles at the start
//               of a fixed FRAME-cycle frame. Optional continuous mode
//               repeats the frame with the same code for averaging.
//
// Ports       : clk          system clock, rising edge
//               rst          asynchronous, active-high reset
//               code_in      requested pulse width in clk cycles (unsigned)
//               load         request valid, accepted when load && ready
//               ready        block can accept a code this cycle (comb.)
//               cont         continuous mode, sampled on last frame cycle
//               pulse_out    generated pulse (registered)
//               frame_start  one-cycle strobe on first cycle of a frame
//               done         one-cycle strobe on last cycle of a frame
//               busy         a frame is in progress
//
// Revision    : 1.0 - initial release
// ============================================================================
module dtc_pulse_gen #(
   parameter int N     = 8,
   parameter int FRAME = 256
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] code_in,
   input  logic         load,
   output logic         ready,
   input  logic         cont,
   output logic         pulse_out,
   output logic         frame_start,
   output logic         done,
   output logic         busy
);

   // Frame-counter width is derived from the frame length.
   localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;

   localparam logic [CW-1:0] c_last_cnt = CW'(FRAME - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [N-1:0]  r_code_q;
   logic [N-1:0]  w_code_nxt;

   logic          w_last;
   logic          w_accept;
   logic [CW:0]   w_cnt_ext;
   logic [CW:0]   w_code_ext;
   logic          w_pulse_nxt;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_code_q <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_code_q <= w_code_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic and combinational handshake
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_code_nxt  = r_code_q;

      w_last   = (r_state == ST_RUN) && (r_cnt == c_last_cnt);
      // ready is gated by rst so nothing can be accepted while reset is held.
      ready    = ~rst && ((r_state == ST_IDLE) || w_last);
      w_accept = load && ready;

      if (w_accept) begin
         // A new code always wins over continuous repeat of the old one.
         w_state_nxt = ST_RUN;
         w_cnt_nxt   = '0;
         w_code_nxt  = code_in;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_last) begin
                  w_cnt_nxt = '0;
                  if (!cont) begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            default: begin
               w_cnt_nxt = '0;
            end
         endcase
      end
   end

   // Counter and code compared at CW+1 bits; CW >= N because FRAME >= 2^N,
   // so the code zero-extension is always at least one bit wide.
   assign w_cnt_ext   = {1'b0, w_cnt_nxt};
   assign w_code_ext  = {{(CW + 1 - N){1'b0}}, w_code_nxt};
   assign w_pulse_nxt = (w_state_nxt == ST_RUN) && (w_cnt_ext < w_code_ext);

   // ------------------------------------------------------------------------
   // Registered outputs, computed from next-state values so that pulse_out,
   // frame_start, done and busy all line up with the counter they describe.
   // The asynchronous reset drops pulse_out immediately mid-frame.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulse_out   <= 1'b0;
         frame_start <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
      end else begin
         pulse_out   <= w_pulse_nxt;
         frame_start <= (w_state_nxt == ST_RUN) && (w_cnt_nxt == '0);
         done        <= (w_state_nxt == ST_RUN) && (w_cnt_nxt == c_last_cnt);
         busy        <= (w_state_nxt == ST_RUN);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dtc_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtc_pulse_gen
// Description : Self-checking bench for dtc_pulse_gen. Accepted codes are
//               pushed to a scoreboard queue; a frame monitor pops one code
//               per frame_start and checks pulse width, pulse shape and
//               frame length at the done strobe. Scenario tasks check
//               timing points inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtc_pulse_gen;

   localparam int N     = 8;
   localparam int FRAME = 256;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] code_in = '0;
   logic         load = 1'b0;
   logic         cont = 1'b0;
   logic         ready;
   logic         pulse_out;
   logic         frame_start;
   logic         done;
   logic         busy;

   int total = 0;
   int bad   = 0;
   int sb[$];

   dtc_pulse_gen #(.N(N), .FRAME(FRAME)) dut (
      .clk         (clk),
      .rst         (rst),
      .code_in     (code_in),
      .load        (load),
      .ready       (ready),
      .cont        (cont),
      .pulse_out   (pulse_out),
      .frame_start (frame_start),
      .done        (done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Frame monitor / scoreboard consumer
   // ------------------------------------------------------------------------
   bit in_frame = 0;
   int flen, pw, exp_code;
   bit shape_ok;

   always @(negedge clk) begin
      if (rst) begin
         in_frame = 0;
      end else begin
         if (frame_start) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_pop: frame_start with empty scoreboard, got frame, required none");
               exp_code = -1;
            end else begin
               exp_code = sb.pop_front();
            end
            in_frame = 1;
            flen = 0;
            pw = 0;
            shape_ok = 1;
         end
         if (in_frame) begin
            if (pulse_out !== (flen < exp_code)) shape_ok = 0;
            if (pulse_out === 1'b1) pw++;
            flen++;
            if (done) begin
               total++;
               if (pw !== exp_code) begin
                  bad++;
                  $display("FAIL sb_width: pulse width got %0d required %0d", pw, exp_code);
               end
               total++;
               if (flen !== FRAME) begin
                  bad++;
                  $display("FAIL sb_frame_len: frame length got %0d required %0d", flen, FRAME);
               end
               total++;
               if (shape_ok !== 1'b1) begin
                  bad++;
                  $display("FAIL sb_shape: pulse not contiguous from frame start, code %0d got %0d required 1",
                           exp_code, shape_ok);
               end
               in_frame = 0;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Scenario tasks (all start and end on a falling edge)
   // ------------------------------------------------------------------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({pulse_out, frame_start, done, busy, ready} !== 5'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b required 00000",
                  {pulse_out, frame_start, done, busy, ready});
      end
      rst = 1'b0;
      #1;
      total++;
      if ({ready, busy} !== 2'b10) begin
         bad++;
         $display("FAIL reset_release: {ready,busy} got %b required 10", {ready, busy});
      end
   endtask

   task automatic test_basic();
      @(negedge clk);
      total++;
      if (ready !== 1'b1) begin
         bad++;
         $display("FAIL basic_ready_idle: got %b required 1", ready);
      end
      code_in = 8'd10; load = 1'b1; sb.push_back(10);
      for (int k = 1; k <= 257; k++) begin
         @(negedge clk);
         if (k == 1) begin
            load = 1'b0;
            code_in = 8'hAA;  // must not be resampled
            total++;
            if ({frame_start, pulse_out, busy} !== 3'b111) begin
               bad++;
               $display("FAIL basic_first: {fs,pulse,busy} got %b required 111",
                        {frame_start, pulse_out, busy});
            end
         end
         if (k == 5) begin
            total++;
            if (ready !== 1'b0) begin
               bad++;
               $display("FAIL basic_ready_mid: got %b required 0", ready);
            end
         end
         if (k == 10 || k == 11) begin
            total++;
            if (pulse_out !== (k == 10)) begin
               bad++;
               $display("FAIL basic_edge_k%0d: pulse got %b required %b", k, pulse_out, (k == 10));
            end
         end
         if (k == 256) begin
            total++;
            if ({done, ready} !== 2'b11) begin
               bad++;
               $display("FAIL basic_done: {done,ready} got %b required 11", {done, ready});
            end
         end
         if (k == 257) begin
            total++;
            if ({busy, ready, done} !== 3'b010) begin
               bad++;
               $display("FAIL basic_idle: {busy,ready,done} got %b required 010", {busy, ready, done});
            end
         end
      end
   endtask

   task automatic test_zero();
      int fs_k = -1, dn_k = -1, hi = 0;
      @(negedge clk);
      code_in = 8'd0; load = 1'b1; sb.push_back(0);
      for (int k = 1; k <= 257; k++) begin
         @(negedge clk);
         if (k == 1) load = 1'b0;
         if (frame_start === 1'b1) fs_k = k;
         if (done === 1'b1) dn_k = k;
         if (pulse_out === 1'b1) hi++;
      end
      total++;
      if (dn_k - fs_k !== 255 || fs_k !== 1) begin
         bad++;
         $display("FAIL zero_spacing: fs at %0d done at %0d, required 1 and 256", fs_k, dn_k);
      end
      total++;
      if (hi !== 0) begin
         bad++;
         $display("FAIL zero_pulse: high cycles got %0d required 0", hi);
      end
   endtask

   task automatic test_cont();
      int fs_list[$];
      @(negedge clk);
      cont = 1'b1;
      code_in = 8'd255; load = 1'b1;
      repeat (3) sb.push_back(255);
      for (int k = 1; k <= 770; k++) begin
         @(negedge clk);
         if (k == 1) load = 1'b0;
         if (k == 300) cont = 1'b0;  // mid-frame blip must have no effect
         if (k == 301) cont = 1'b1;
         if (k == 600) cont = 1'b0;  // ends after the third frame
         if (frame_start === 1'b1) fs_list.push_back(k);
         if (k == 769) begin
            total++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL cont_stop: busy got %b required 0", busy);
            end
         end
      end
      total++;
      if (fs_list.size() !== 3 || fs_list[0] !== 1 || fs_list[1] !== 257 || fs_list[2] !== 513) begin
         bad++;
         $display("FAIL cont_starts: count %0d first %0d, required 3 starts at 1,257,513",
                  fs_list.size(), (fs_list.size() > 0) ? fs_list[0] : -1);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      code_in = 8'd5; load = 1'b1; sb.push_back(5);
      for (int k = 1; k <= 513; k++) begin
         @(negedge clk);
         if (k == 1 || k == 101 || k == 257) load = 1'b0;
         if (k == 100) begin
            total++;
            if (ready !== 1'b0) begin
               bad++;
               $display("FAIL b2b_ready_mid: got %b required 0", ready);
            end
            code_in = 8'd99; load = 1'b1;  // ignored
         end
         if (k == 256) begin
            total++;
            if ({done, ready, busy} !== 3'b111) begin
               bad++;
               $display("FAIL b2b_done: {done,ready,busy} got %b required 111", {done, ready, busy});
            end
            code_in = 8'd20; load = 1'b1; sb.push_back(20);
         end
         if (k == 257) begin
            total++;
            if ({frame_start, pulse_out, busy} !== 3'b111) begin
               bad++;
               $display("FAIL b2b_no_gap: {fs,pulse,busy} got %b required 111",
                        {frame_start, pulse_out, busy});
            end
         end
         if (k == 513) begin
            total++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL b2b_idle: busy got %b required 0", busy);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int hi = 0;
      @(negedge clk);
      code_in = 8'd50; load = 1'b1; sb.push_back(50);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) load = 1'b0;
      end
      total++;
      if (pulse_out !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_pre: pulse got %b required 1", pulse_out);
      end
      rst = 1'b1;
      #1;
      sb.delete();
      total++;
      if ({pulse_out, ready, busy, done} !== 4'b0000) begin
         bad++;
         $display("FAIL rstmid_async: {pulse,ready,busy,done} got %b required 0000",
                  {pulse_out, ready, busy, done});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if ({ready, busy, done} !== 3'b100) begin
         bad++;
         $display("FAIL rstmid_release: {ready,busy,done} got %b required 100", {ready, busy, done});
      end
      @(negedge clk);
      code_in = 8'd7; load = 1'b1; sb.push_back(7);
      for (int k = 1; k <= 257; k++) begin
         @(negedge clk);
         if (k == 1) load = 1'b0;
         if (pulse_out === 1'b1) hi++;
      end
      total++;
      if (hi !== 7) begin
         bad++;
         $display("FAIL rstmid_reload: pulse cycles got %0d required 7", hi);
      end
   endtask

   // Behavioural TDC (thermometer capture) followed by unary-to-binary decode.
   task automatic test_loopback();
      int codes[4] = '{1, 64, 128, 200};
      int prev = -1;
      logic [FRAME-1:0] therm;
      int out_bin;
      foreach (codes[i]) begin
         @(negedge clk);
         code_in = N'(codes[i]); load = 1'b1; sb.push_back(codes[i]);
         therm = '0;
         for (int k = 1; k <= 257; k++) begin
            @(negedge clk);
            if (k == 1) load = 1'b0;
            if (k <= FRAME) therm[k-1] = pulse_out;
         end
         out_bin = FRAME;
         for (int b = FRAME - 1; b >= 0; b--) if (therm[b] !== 1'b1) out_bin = b;
         total++;
         if (out_bin !== codes[i] || out_bin <= prev) begin
            bad++;
            $display("FAIL loopback_code%0d: out_bin got %0d required %0d (prev %0d)",
                     codes[i], out_bin, codes[i], prev);
         end
         prev = out_bin;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_cont();
      test_back_to_back();
      test_reset_mid();
      test_loopback();
      repeat (2) @(negedge clk);
      total++;
      if (sb.size() !== 0) begin
         bad++;
         $display("FAIL sb_drain: leftover entries got %0d required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dtc_pulse_gen.md
Name: dtc_pulse_gen

Overview:
Digital-to-time converter: the inverse of the TDC/thermometer-decode chain. It takes an N-bit binary code and emits a single pulse of exactly `code` clock cycles inside a fixed-length frame. The block provides a known-width start stimulus for TDC calibration and loopback (code in -> pulse -> TDC -> unary2binary -> code out). It also has a continuous mode that repeats the frame for averaging.

Parameters:
- N, 8, code width in bits.
- FRAME, 256, frame length in clk cycles; must satisfy FRAME >= 2^N and FRAME >= 2.
- CW, $clog2(FRAME), frame-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- code_in  input  N  requested pulse width in clk cycles, unsigned.
- load  input  1  request valid; accepted when load && ready.
- ready  output  1  block can accept a code this cycle.
- cont  input  1  continuous mode; sampled on the last cycle of each frame.
- pulse_out  output  1  generated pulse, registered.
- frame_start  output  1  one-cycle strobe on the first cycle of each frame.
- done  output  1  one-cycle strobe on the last cycle of each frame.
- busy  output  1  a frame is in progress.

Behaviour:
- States: IDLE and RUN. Internal registers: code_q[N-1:0] and cnt[CW-1:0].
- Reset while rst is high:
  - state=IDLE, cnt=0, code_q=0.
  - pulse_out=0, frame_start=0, done=0, busy=0.
  - ready is forced to 0 while rst is high.
- ready = ~rst && (state==IDLE || (state==RUN && cnt==FRAME-1)). It is combinational.
- Accept (load && ready) at cycle t:
  - code_q <= code_in.
  - From cycle t+1: state=RUN, cnt=0.
- Frame timing, frame first cycle = f, cnt counts 0..FRAME-1:
  - frame_start=1 at cnt==0 only.
  - pulse_out=1 exactly when cnt < code_q, i.e. cycles f .. f+code_q-1.
  - pulse_out is registered, driven from next-state values so it aligns with frame_start.
  - busy=1 for every RUN cycle.
  - done=1 at cnt==FRAME-1.
- Latency: code accepted at t gives the pulse rising edge at t+1.
- code_q==0: no pulse in that frame; frame_start, done and busy behave normally.
- code_q==2^N-1: pulse high for 2^N-1 cycles. Because FRAME >= 2^N, at least one low cycle always follows.
- Last cycle of a frame (cnt==FRAME-1):
  - load accepted: new frame starts the next cycle with the new code. No gap, and the new code has priority over cont.
  - else if cont==1: new frame starts the next cycle with the same code_q.
  - else: IDLE next cycle, busy drops.
- load while RUN with cnt != FRAME-1: ignored (ready=0). code_q is unchanged and there is no queueing.
- cont changes mid-frame: no effect until it is sampled at cnt==FRAME-1.
- cnt wraps from FRAME-1 to 0 only on frame restart; otherwise it holds 0 in IDLE.
- Reset mid-frame: pulse_out drops immediately (asynchronous). No done strobe is issued. After release the block is IDLE with ready=1.
- code_in is only sampled on accept; changes at any other time are ignored.

Test Plan:
- Reset, then load with code_in=8'd10 at cycle t -> frame_start at t+1; pulse_out high t+1..t+10; done at t+256; ready=1 at t+256; IDLE, busy=0 at t+257.
- code_in=0 -> no pulse_out for the whole frame; frame_start and done are still seen 255 cycles apart.
- code_in=255, cont=1 held for 3 frames -> three consecutive 255-cycle pulses, each followed by exactly 1 low cycle; frame_start every 256 cycles.
- Back-to-back: load code 5 accepted, then load code 20 asserted at the done cycle -> second frame starts with no gap; pulses of 5 then 20 cycles. Also apply load=1 mid-frame -> ignored, code unchanged.
- Assert rst at pulse cycle 3 of a code-50 frame -> pulse_out=0 immediately; ready=0 during reset; after release ready=1, and a new load of code 7 produces a 7-cycle pulse.
- Loopback through TDC + unary2binary for codes {1, 64, 128, 200} -> out_bin is monotonic in code (calibration sanity check).
